// File: rtl/tinker_fetch_queue.sv
// Tinker instruction fetch stage: sequential prefetch into a small {pc, word}
// queue, with redirect flush and drop-counting of stale in-flight responses.
module tinker_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h2000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUT + 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   word_mem [DEPTH];

  logic [31:0] target;
  logic [31:0] live;
  logic [31:0] occupancy;
  logic        req_fire;
  logic        resp_ok;
  logic        drop;
  logic        push;
  logic        pop;

  assign target = redirect_pc & 32'hFFFF_FFFC;

  // Reserve a queue slot for every live in-flight request so pushes never overflow.
  always_comb begin
    live          = 32'(outstanding) - 32'(drop_cnt);
    occupancy     = 32'(count) + live;
    mem_req_valid = !reset && !redirect_valid &&
                    (32'(outstanding) < MAX_OUT) && (occupancy < DEPTH);
  end

  assign mem_req_addr = fetch_pc;
  assign req_fire     = mem_req_valid && mem_req_ready;
  assign resp_ok      = mem_resp_valid && (outstanding != '0);
  assign drop         = resp_ok && (drop_cnt != '0);
  assign push         = resp_ok && !drop;

  assign inst_valid = (count != '0);
  assign inst       = word_mem[head];
  assign inst_pc    = pc_mem[head];
  assign pop        = inst_valid && inst_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        word_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Everything still in flight after this cycle's response is stale.
      fetch_pc    <= target;
      resp_pc     <= target;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      outstanding <= outstanding - OW'(resp_ok);
      drop_cnt    <= outstanding - OW'(resp_ok);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding + OW'(req_fire) - OW'(resp_ok);
      if (drop) drop_cnt <= drop_cnt - OW'(1);
      if (push) begin
        pc_mem[tail]   <= resp_pc;
        word_mem[tail] <= mem_resp_data;
        tail           <= tail + PW'(1);
        resp_pc        <= resp_pc + 32'd4;
      end
      if (pop) head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_tinker_fetch_queue.sv
// Bench for tinker_fetch_queue: latency-programmable in-order memory responder,
// queue-based reference model compared every cycle, plus directed literal checks.
module tb_tinker_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h2000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b1;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b1;

  tinker_fetch_queue #(
    .DEPTH(DEPTH),
    .MAX_OUT(MAX_OUT),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD0000;
  endfunction

  // Memory: accepted requests return in order after 'lat' cycles.
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  always @(negedge clk) begin
    if (mem_req_valid && mem_req_ready && !reset) begin
      pend_addr.push_back(mem_req_addr);
      pend_due.push_back(cyc + lat);
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
    end
  end

  // Reference model: in-flight list tagged stale on redirect, and an instruction queue.
  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } infl_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  infl_t       m_infl[$];
  ent_t        m_q[$];
  logic [31:0] m_fetch = RESET_PC;
  logic        m_ev;

  function automatic int live_cnt();
    int n = 0;
    foreach (m_infl[i]) if (!m_infl[i].stale) n++;
    return n;
  endfunction

  function automatic logic exp_req_valid();
    return !reset && !redirect_valid && (m_infl.size() < int'(MAX_OUT)) &&
           ((m_q.size() + live_cnt()) < int'(DEPTH));
  endfunction

  task automatic model_reset();
    m_infl.delete();
    m_q.delete();
    m_fetch = RESET_PC;
  endtask

  task automatic model_step(input logic ev);
    infl_t e;
    bit    popq;
    if (redirect_valid) begin
      m_fetch = {redirect_pc[31:2], 2'b00};
      m_q.delete();
      if (mem_resp_valid && m_infl.size() > 0) void'(m_infl.pop_front());
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
    end else begin
      popq = (m_q.size() != 0) && inst_ready;
      if (popq) void'(m_q.pop_front());
      if (mem_resp_valid && m_infl.size() > 0) begin
        e = m_infl.pop_front();
        if (!e.stale) m_q.push_back('{pc: e.addr, word: mem_resp_data});
      end
      if (ev && mem_req_ready) begin
        m_infl.push_back('{addr: m_fetch, stale: 1'b0});
        m_fetch = m_fetch + 32'd4;
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) model_reset();
    m_ev = exp_req_valid();
    chk("req_valid", 32'(mem_req_valid), 32'(m_ev));
    chk("req_addr", mem_req_addr, m_fetch);
    chk("inst_valid", 32'(inst_valid), 32'(m_q.size() != 0));
    if (reset) begin
      chk("rst_inst", inst, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
    end else if (m_q.size() != 0) begin
      chk("inst", inst, m_q[0].word);
      chk("inst_pc", inst_pc, m_q[0].pc);
    end
    if (!reset) model_step(m_ev);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_inst(input string name, input logic [31:0] pc);
    #1;
    for (int i = 0; i < 30; i++) begin
      if (inst_valid) break;
      tick(1);
      #1;
    end
    chk({name, "_valid"}, 32'(inst_valid), 32'h1);
    chk({name, "_pc"}, inst_pc, pc);
    chk({name, "_word"}, inst, mem_word(pc));
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_req_valid"}, 32'(mem_req_valid), 32'h0);
    chk({name, "_req_addr"}, mem_req_addr, RESET_PC);
    chk({name, "_inst_valid"}, 32'(inst_valid), 32'h0);
    chk({name, "_inst"}, inst, 32'h0);
    chk({name, "_inst_pc"}, inst_pc, 32'h0);
  endtask

  initial begin
    bit found;

    // Reset held, then stream with L=1.
    tick(2);
    #1 check_reset_outputs("rst");
    reset = 1'b0;
    tick(2);
    #1;
    chk("stream_first_valid", 32'(inst_valid), 32'h1);
    chk("stream_first_pc", inst_pc, 32'h2000);
    chk("stream_first_word", inst, 32'hDEAD2000);
    tick(1);
    #1;
    chk("stream_second_pc", inst_pc, 32'h2004);
    chk("stream_second_valid", 32'(inst_valid), 32'h1);
    tick(6);

    // Back-pressure: queue fills to DEPTH, requests stop, then drains in order.
    reset = 1'b1;
    inst_ready = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(8);
    #1;
    chk("bp_req_stopped", 32'(mem_req_valid), 32'h0);
    chk("bp_head_pc", inst_pc, 32'h2000);
    inst_ready = 1'b1;
    tick(1);
    #1 chk("bp_drain_pc", inst_pc, 32'h2004);
    tick(6);

    // Memory not ready for 5 cycles: address holds at the reset PC.
    reset = 1'b1;
    mem_req_ready = 1'b0;
    tick(1);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_addr", mem_req_addr, 32'h2000);
      chk("stall_valid", 32'(mem_req_valid), 32'h1);
      tick(1);
    end
    mem_req_ready = 1'b1;
    tick(2);
    #1 chk("stall_first_pc", inst_pc, 32'h2000);
    tick(3);

    // Redirect with two stale requests in flight (L=3).
    reset = 1'b1;
    lat = 3;
    tick(1);
    reset = 1'b0;
    tick(2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h3002;
    #1 chk("redir_no_req", 32'(mem_req_valid), 32'h0);
    tick(1);
    redirect_valid = 1'b0;
    #1 chk("redir_addr", mem_req_addr, 32'h3000);
    wait_inst("redir_first", 32'h3000);
    tick(3);

    // Redirect coinciding with a response and a pop, two requests outstanding.
    lat = 2;
    inst_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (mem_resp_valid && m_q.size() > 0 && m_infl.size() == 2) begin
        found = 1'b1;
        break;
      end
    end
    chk("coin_trigger", 32'(found), 32'h1);
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h4000;
    tick(1);
    redirect_valid = 1'b0;
    #1 chk("coin_empty", 32'(inst_valid), 32'h0);
    wait_inst("coin_first", 32'h4000);

    // Back-to-back redirects: last target wins.
    tick(2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h5000;
    tick(1);
    redirect_pc = 32'h6006;
    tick(1);
    redirect_valid = 1'b0;
    wait_inst("b2b_first", 32'h6004);
    tick(4);

    // Asynchronous reset mid-stream with two requests outstanding.
    reset = 1'b1;
    lat = 3;
    tick(1);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    #1 check_reset_outputs("arst");
    tick(1);
    mem_req_ready = 1'b0;
    reset = 1'b0;
    tick(4);
    lat = 1;
    mem_req_ready = 1'b1;
    #1;
    chk("arst_restart_addr", mem_req_addr, 32'h2000);
    chk("arst_restart_valid", 32'(mem_req_valid), 32'h1);
    chk("arst_queue_empty", 32'(inst_valid), 32'h0);
    wait_inst("arst_first", 32'h2000);
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
